// File: rtl/display_pkg.sv
// Shared display-pipeline constants and types for the sprite read path.
package display_pkg;

  // Sprite geometry and colour key.
  localparam int unsigned SPR_W       = 30;
  localparam int unsigned SPR_H       = 30;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned DATA_W      = 16;
  localparam logic [15:0] KEY_COLOR   = 16'hF81F;

  // Screen coordinate widths.
  localparam int unsigned X_W         = 11;
  localparam int unsigned Y_W         = 10;

  // Animation: frame_start pulses per step, and number of bird frames.
  localparam int unsigned ANIM_DIV    = 8;
  localparam int unsigned ANIM_FRAMES = 3;

  typedef logic [DATA_W-1:0] rgb565_t;
  typedef logic [1:0]        anim_idx_t;

  // Per-pixel side information carried down the pipeline next to the ROM access.
  typedef struct packed {
    logic      valid;
    logic      in_box;
    rgb565_t   bg;
    anim_idx_t anim;
  } pix_stage_t;

  // Next animation frame, wrapping after the last bird frame.
  function automatic anim_idx_t anim_next(anim_idx_t idx);
    if (idx >= anim_idx_t'(ANIM_FRAMES - 1)) begin
      return '0;
    end
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/sprite_pixel_reader_if.sv
// Scan-in / ROM / composited-pixel-out bundle of the sprite pixel reader.
interface sprite_pixel_reader_if #(
  parameter int unsigned ADDR_W = display_pkg::ADDR_W,
  parameter int unsigned DATA_W = display_pkg::DATA_W,
  parameter int unsigned X_W    = display_pkg::X_W,
  parameter int unsigned Y_W    = display_pkg::Y_W
);
  // Frame-level sprite placement.
  logic              frame_start;
  logic              spr_en;
  logic [X_W-1:0]    spr_x;
  logic [Y_W-1:0]    spr_y;
  // Scan position and background.
  logic              pix_valid;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [DATA_W-1:0] bg_color;
  // Shared frame-ROM port.
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data0;
  logic [DATA_W-1:0] rom_data1;
  logic [DATA_W-1:0] rom_data2;
  // Results.
  logic [1:0]        anim_idx;
  logic              out_valid;
  logic              out_hit;
  logic [DATA_W-1:0] out_color;

  modport slave (
    input  frame_start, spr_en, spr_x, spr_y,
    input  pix_valid, pix_x, pix_y, bg_color,
    input  rom_data0, rom_data1, rom_data2,
    output rom_addr, anim_idx, out_valid, out_hit, out_color
  );

  modport master (
    output frame_start, spr_en, spr_x, spr_y,
    output pix_valid, pix_x, pix_y, bg_color,
    output rom_data0, rom_data1, rom_data2,
    input  rom_addr, anim_idx, out_valid, out_hit, out_color
  );
endinterface

// File: rtl/sprite_anim_ctr.sv
// Divides frame_start pulses and steps the bird animation frame 0->1->2->0.
module sprite_anim_ctr #(
  parameter int unsigned ANIM_DIV = display_pkg::ANIM_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  output logic [1:0] anim_idx
);
  import display_pkg::*;

  localparam int unsigned CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  // Count frame_start pulses; advance the animation frame on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      anim_idx <= '0;
    end else if (frame_start) begin
      if (div_cnt == CNT_LAST) begin
        div_cnt  <= '0;
        anim_idx <= anim_next(anim_idx);
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_pixel_reader.sv
// Sprite read engine: scan position -> ROM address -> frame select -> colour-key composite.
// Three-cycle pipeline: stage 1 address, stage 2 ROM read, stage 3 output register.
module sprite_pixel_reader #(
  parameter int unsigned       SPR_W     = display_pkg::SPR_W,
  parameter int unsigned       SPR_H     = display_pkg::SPR_H,
  parameter int unsigned       ADDR_W    = display_pkg::ADDR_W,
  parameter int unsigned       DATA_W    = display_pkg::DATA_W,
  parameter int unsigned       X_W       = display_pkg::X_W,
  parameter int unsigned       Y_W       = display_pkg::Y_W,
  parameter logic [DATA_W-1:0] KEY_COLOR = display_pkg::KEY_COLOR,
  parameter int unsigned       ANIM_DIV  = display_pkg::ANIM_DIV
) (
  input logic                  clk,
  input logic                  rst_n,
  sprite_pixel_reader_if.slave bus
);
  import display_pkg::*;

  // Box bounds are evaluated one bit wider so x+SPR_W / y+SPR_H never wrap.
  localparam int unsigned XE = X_W + 1;
  localparam int unsigned YE = Y_W + 1;

  logic              spr_en_q;
  logic [X_W-1:0]    spr_x_q;
  logic [Y_W-1:0]    spr_y_q;
  logic [1:0]        anim_idx;

  logic [XE-1:0]     px_e, x_lo, x_hi;
  logic [YE-1:0]     py_e, y_lo, y_hi;
  logic              in_box;
  logic [X_W-1:0]    dx;
  logic [Y_W-1:0]    dy;
  logic [ADDR_W-1:0] addr_calc;

  pix_stage_t        s1, s2;
  logic [ADDR_W-1:0] rom_addr;

  logic [DATA_W-1:0] rom_data;
  logic              hit;
  logic              out_valid, out_hit;
  logic [DATA_W-1:0] out_color;

  sprite_anim_ctr #(
    .ANIM_DIV (ANIM_DIV)
  ) u_anim_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (bus.frame_start),
    .anim_idx    (anim_idx)
  );

  // Capture sprite placement once per frame; a pixel in the same cycle still sees the old one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_en_q <= 1'b0;
      spr_x_q  <= '0;
      spr_y_q  <= '0;
    end else if (bus.frame_start) begin
      spr_en_q <= bus.spr_en;
      spr_x_q  <= bus.spr_x;
      spr_y_q  <= bus.spr_y;
    end
  end

  // Hit-box test and sprite-relative ROM address for the current scan position.
  always_comb begin
    px_e      = {1'b0, bus.pix_x};
    py_e      = {1'b0, bus.pix_y};
    x_lo      = {1'b0, spr_x_q};
    y_lo      = {1'b0, spr_y_q};
    x_hi      = x_lo + XE'(SPR_W);
    y_hi      = y_lo + YE'(SPR_H);
    in_box    = spr_en_q && (px_e >= x_lo) && (px_e < x_hi) && (py_e >= y_lo) && (py_e < y_hi);
    dx        = bus.pix_x - spr_x_q;
    dy        = bus.pix_y - spr_y_q;
    addr_calc = ADDR_W'(32'(dy) * 32'(SPR_W) + 32'(dx));
  end

  // Stages 1 and 2: issue the ROM address, carry side info alongside the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      rom_addr <= '0;
    end else begin
      s1.valid  <= bus.pix_valid;
      s1.in_box <= bus.pix_valid && in_box;
      s1.bg     <= bus.bg_color;
      s1.anim   <= anim_idx;
      // Address only moves for covered pixels, so it holds across background runs.
      if (bus.pix_valid && in_box) begin
        rom_addr <= addr_calc;
      end
      s2 <= s1;
    end
  end

  // Pick the frame that was current when this pixel entered, then apply the colour key.
  always_comb begin
    case (s2.anim)
      2'd1:    rom_data = bus.rom_data1;
      2'd2:    rom_data = bus.rom_data2;
      default: rom_data = bus.rom_data0;
    endcase
    hit = s2.in_box && (rom_data != KEY_COLOR);
  end

  // Stage 3: composited output register; colour holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= s2.valid;
      if (s2.valid) begin
        out_hit   <= hit;
        out_color <= hit ? rom_data : s2.bg;
      end else begin
        out_hit <= 1'b0;
      end
    end
  end

  assign bus.rom_addr  = rom_addr;
  assign bus.anim_idx  = anim_idx;
  assign bus.out_valid = out_valid;
  assign bus.out_hit   = out_hit;
  assign bus.out_color = out_color;

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Bench for sprite_pixel_reader: directed cases plus randomized scan against a behavioural model.
module tb_sprite_pixel_reader;
  localparam int SW  = 30;
  localparam int SH  = 30;
  localparam int AD  = 8;
  localparam logic [15:0] KEY = 16'hF81F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_pixel_reader_if bus ();

  sprite_pixel_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Three frame ROMs with registered address, data valid the following cycle.
  logic [15:0] rom [3][1024];
  always @(posedge clk) begin
    bus.rom_data0 <= rom[0][bus.rom_addr];
    bus.rom_data1 <= rom[1][bus.rom_addr];
    bus.rom_data2 <= rom[2][bus.rom_addr];
  end

  int errors = 0;
  int checks = 0;
  bit running = 1'b1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          v;
    bit          h;
    logic [15:0] c;
  } rec_t;

  rec_t        pq[$];
  rec_t        m_r;
  bit          m_en;
  int          m_x, m_y, m_fc, m_a, m_px, m_py, m_addr;
  logic [15:0] m_d;
  bit          cur_v, cur_h;
  logic [15:0] cur_c;
  logic [9:0]  exp_addr;
  int          exp_anim;

  // Output for a pixel appears two edges after the edge that samples it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq.delete();
      m_en = 0; m_x = 0; m_y = 0; m_fc = 0;
      cur_v = 0; cur_h = 0; cur_c = '0;
      exp_addr = '0; exp_anim = 0;
    end else begin
      m_a   = (m_fc / AD) % 3;
      m_r.v = bus.pix_valid;
      m_r.h = 1'b0;
      m_r.c = bus.bg_color;
      if (bus.pix_valid) begin
        m_px = int'(bus.pix_x);
        m_py = int'(bus.pix_y);
        if (m_en && m_px >= m_x && m_px < m_x + SW && m_py >= m_y && m_py < m_y + SH) begin
          m_addr   = ((m_py - m_y) * SW + (m_px - m_x)) % 1024;
          exp_addr = m_addr[9:0];
          m_d      = rom[m_a][m_addr];
          m_r.h    = (m_d != KEY);
          if (m_r.h) m_r.c = m_d;
        end
      end
      pq.push_back(m_r);
      if (pq.size() == 3) begin
        m_r   = pq.pop_front();
        cur_v = m_r.v;
        cur_h = m_r.v && m_r.h;
        if (m_r.v) cur_c = m_r.c;
      end else begin
        cur_v = 0;
        cur_h = 0;
      end
      if (bus.frame_start) begin
        m_en = bus.spr_en;
        m_x  = int'(bus.spr_x);
        m_y  = int'(bus.spr_y);
        m_fc++;
      end
      exp_anim = (m_fc / AD) % 3;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      chk("out_valid", bus.out_valid, cur_v);
      chk("out_hit", bus.out_hit, cur_h);
      chk("out_color", bus.out_color, cur_c);
      chk("rom_addr", bus.rom_addr, exp_addr);
      chk("anim_idx", bus.anim_idx, exp_anim);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic frame(bit en, int x, int y);
    bus.frame_start = 1'b1;
    bus.spr_en      = en;
    bus.spr_x       = 11'(x);
    bus.spr_y       = 10'(y);
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic pix(int x, int y, logic [15:0] bg);
    bus.pix_valid = 1'b1;
    bus.pix_x     = 11'(x);
    bus.pix_y     = 10'(y);
    bus.bg_color  = bg;
    step();
    bus.pix_valid = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  // Pixel then wait for its result; returns at the cycle the result is on the outputs.
  task automatic pix_out(string name, int x, int y, logic [15:0] bg, bit hit, logic [15:0] col);
    pix(x, y, bg);
    step();
    step();
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_hit"}, bus.out_hit, hit);
    chk({name, "_color"}, bus.out_color, col);
  endtask

  logic [15:0] v;
  logic [6:0]  pat;
  int          st_x, st_y;

  initial begin
    rst_n           = 1'b0;
    bus.frame_start = 1'b0;
    bus.spr_en      = 1'b0;
    bus.spr_x       = '0;
    bus.spr_y       = '0;
    bus.pix_valid   = 1'b0;
    bus.pix_x       = '0;
    bus.pix_y       = '0;
    bus.bg_color    = '0;
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 1024; a++) begin
        v = 16'($urandom);
        if ($urandom_range(0, 7) == 0) v = KEY;
        if (v == KEY && a < 40) v = 16'h0101;
        rom[k][a] = v;
      end
    end
    rom[0][0]   = 16'h1234;
    rom[0][899] = 16'h4321;
    rom[0][31]  = KEY;
    rom[0][7]   = 16'h0777;
    rom[1][0]   = 16'h0BEE;

    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_color", bus.out_color, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_anim", bus.anim_idx, 0);
    rst_n = 1'b1;
    step();

    // Sprite at (100,50): corners, just-outside pixels, colour key.
    frame(1, 100, 50);
    pix(100, 50, 16'h0AAA);
    chk("addr_topleft", bus.rom_addr, 0);
    step(); step();
    chk("topleft_valid", bus.out_valid, 1);
    chk("topleft_color", bus.out_color, 16'h1234);
    pix(129, 79, 16'h0555);
    chk("addr_botright", bus.rom_addr, 899);
    step(); step();
    chk("botright_color", bus.out_color, 16'h4321);
    pix_out("right_out", 130, 79, 16'h0666, 0, 16'h0666);
    chk("addr_hold", bus.rom_addr, 899);
    pix_out("left_out", 99, 50, 16'h0777, 0, 16'h0777);
    pix_out("keyed", 101, 51, 16'h001F, 0, 16'h001F);

    // frame_start coincident with a pixel: pixel sees the old placement.
    bus.frame_start = 1'b1;
    bus.spr_en      = 1'b1;
    bus.spr_x       = 11'd500;
    bus.spr_y       = 10'd300;
    pix(100, 50, 16'h0888);
    bus.frame_start = 1'b0;
    chk("coinc_addr", bus.rom_addr, 0);
    step(); step();
    chk("coinc_hit", bus.out_hit, 1);
    chk("coinc_color", bus.out_color, 16'h1234);
    pix_out("after_move", 100, 50, 16'h0999, 0, 16'h0999);

    // Right edge near the x maximum must not wrap.
    frame(1, 2040, 10);
    pix(2047, 10, 16'h0ABC);
    chk("edge_addr", bus.rom_addr, 7);
    step(); step();
    chk("edge_color", bus.out_color, 16'h0777);
    pix_out("edge_wrap", 5, 10, 16'h0DEF, 0, 16'h0DEF);

    // Burst with a two-cycle gap, then reset mid-burst.
    frame(1, 100, 50);
    pat = 7'b1100111;
    for (int i = 0; i < 7; i++) begin
      bus.pix_valid = pat[i];
      bus.pix_x     = 11'(100 + i);
      bus.pix_y     = 10'd52;
      bus.bg_color  = 16'(16'h0C00 + i);
      step();
    end
    bus.pix_valid = 1'b1;
    rst_n = 1'b0;
    step();
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_color", bus.out_color, 0);
    bus.pix_valid = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("postrst_valid", bus.out_valid, 0);
    chk("postrst_hit", bus.out_hit, 0);
    chk("postrst_color", bus.out_color, 0);

    // Animation stepping: every 8 frame_start pulses.
    do_reset(2);
    for (int i = 1; i <= 24; i++) begin
      frame(1, 100, 50);
      if (i == 7)  chk("anim_7", bus.anim_idx, 0);
      if (i == 8) begin
        chk("anim_8", bus.anim_idx, 1);
        pix_out("frame1_data", 100, 50, 16'h0000, 1, 16'h0BEE);
      end
      if (i == 16) chk("anim_16", bus.anim_idx, 2);
      if (i == 24) chk("anim_24", bus.anim_idx, 0);
    end

    // Sprite disabled: background everywhere.
    frame(0, 100, 50);
    pix_out("disabled", 100, 50, 16'h0F0F, 0, 16'h0F0F);

    // Randomized scan around the sprite.
    st_x = 100;
    st_y = 50;
    for (int c = 0; c < 4000; c++) begin
      bus.frame_start = ($urandom_range(0, 39) == 0);
      if (bus.frame_start) begin
        if ($urandom_range(0, 3) == 0) begin
          st_x = int'($urandom_range(2000, 2047));
          st_y = int'($urandom_range(990, 1023));
        end else begin
          st_x = int'($urandom_range(0, 700));
          st_y = int'($urandom_range(0, 500));
        end
        bus.spr_en = ($urandom_range(0, 3) != 0);
        bus.spr_x  = 11'(st_x);
        bus.spr_y  = 10'(st_y);
      end
      bus.pix_valid = ($urandom_range(0, 3) != 0);
      bus.pix_x     = 11'(st_x + int'($urandom_range(0, 40)) - 5);
      bus.pix_y     = 10'(st_y + int'($urandom_range(0, 40)) - 5);
      bus.bg_color  = 16'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    repeat (4) step();

    running = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
